dds_sweep_generator: RTL and testbench

Direct-digital-synthesis sine source with a built-in linear frequency-sweep sequencer. It produces the signed test stimulus that feeds the noise adder and `iir_filter`, and is the upstream stage of the filter chain. A 32-bit phase accumulator indexes a sine LUT. A small FSM steps the frequency control word (FCW) through a programmed sweep, so frequency-response runs need no testbench-side FCW poking.

---
 rtl/dds_sweep_generator.sv | 139 +++++++++++++
 tb/tb_dds_sweep_generator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_generator.sv
// dds_sweep_generator
// Sine source built from a 32-bit phase accumulator and a sine lookup table.
// A small sequencer steps the frequency control word (FCW) through a linear
// sweep: num_steps steps, each lasting dwell_cycles samples.
module dds_sweep_generator #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 32,
  parameter int ADDR_W     = 10,
  parameter int AMP        = 16383
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [N-1:0]                 start_fcw,
  input  logic [N-1:0]                 step_fcw,
  input  logic [15:0]                  num_steps,
  input  logic [15:0]                  dwell_cycles,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_valid,
  output logic [N-1:0]                 fcw_out,
  output logic [15:0]                  step_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int  LUT_SIZE = 2 ** ADDR_W;
  localparam real PI       = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t        state_reg;
  logic [N-1:0]  phase_reg;
  logic [15:0]   dwell_cnt_reg;
  logic [15:0]   steps_reg;
  logic [15:0]   dwell_reg;
  logic [N-1:0]  step_fcw_reg;
  logic [ADDR_W-1:0] lut_addr;

  // Read-only sine table, one full period, evaluated at elaboration time.
  // int'() rounds to nearest, giving round(AMP * sin(2*pi*k/LUT_SIZE)).
  logic signed [DATA_WIDTH-1:0] lut [LUT_SIZE];

  generate
    for (genvar gi = 0; gi < LUT_SIZE; gi++) begin : g_lut
      localparam real ANGLE = 2.0 * PI * gi / LUT_SIZE;
      localparam int  VAL   = int'(AMP * $sin(ANGLE));
      assign lut[gi] = DATA_WIDTH'(VAL);
    end
  endgenerate

  // Table address is the truncated top of the phase; no dithering.
  assign lut_addr = phase_reg[N-1 -: ADDR_W];

  // Sweep sequencer: accumulates phase, registers the table read and steps the FCW.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      dwell_cnt_reg <= '0;
      steps_reg     <= '0;
      dwell_reg     <= '0;
      step_fcw_reg  <= '0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      fcw_out       <= '0;
      step_idx      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          phase_reg     <= '0;
          dwell_cnt_reg <= '0;
          fcw_out       <= '0;
          step_idx      <= '0;
          sample_valid  <= 1'b0;
          busy          <= 1'b0;
          if (start) begin
            // A zero length would never terminate, so treat it as one.
            steps_reg    <= (num_steps == 16'd0) ? 16'd1 : num_steps;
            dwell_reg    <= (dwell_cycles == 16'd0) ? 16'd1 : dwell_cycles;
            step_fcw_reg <= step_fcw;
            fcw_out      <= start_fcw;
            busy         <= 1'b1;
            state_reg    <= SWEEP;
          end
        end

        SWEEP: begin
          if (stop) begin
            // Abort wins over the final-step transition; no done pulse.
            state_reg     <= IDLE;
            phase_reg     <= '0;
            dwell_cnt_reg <= '0;
            fcw_out       <= '0;
            step_idx      <= '0;
            sample_valid  <= 1'b0;
            busy          <= 1'b0;
          end else begin
            phase_reg    <= phase_reg + fcw_out;
            sample_out   <= lut[lut_addr];
            sample_valid <= 1'b1;
            if (dwell_cnt_reg == dwell_reg - 16'd1) begin
              dwell_cnt_reg <= '0;
              if (step_idx == steps_reg - 16'd1) begin
                state_reg <= DONE;
              end else begin
                // Modular add: a two's-complement step sweeps downward.
                step_idx <= step_idx + 16'd1;
                fcw_out  <= fcw_out + step_fcw_reg;
              end
            end else begin
              dwell_cnt_reg <= dwell_cnt_reg + 16'd1;
            end
          end
        end

        DONE: begin
          // Clear the sweep state here so IDLE is entered with zeroed outputs.
          state_reg     <= IDLE;
          phase_reg     <= '0;
          dwell_cnt_reg <= '0;
          fcw_out       <= '0;
          step_idx      <= '0;
          sample_valid  <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_generator.sv
// Directed testbench for dds_sweep_generator with hand-computed expectations.
module tb_dds_sweep_generator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic [31:0]        start_fcw;
  logic [31:0]        step_fcw;
  logic [15:0]        num_steps;
  logic [15:0]        dwell_cycles;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic [31:0]        fcw_out;
  logic [15:0]        step_idx;
  logic               busy;
  logic               done;

  int vectors     = 0;
  int miscompares = 0;

  // LUT[k] for the indices visited by the sweeps below.
  int exp_fixed [8]  = '{0, 101, 201, 302, 402, 503, 603, 703};
  int exp_sweep [12] = '{0, 101, 201, 302, 402, 603, 804, 1005, 1205, 1506, 1806, 2105};

  logic signed [15:0] audio [96];
  logic [31:0]        exp_f;
  logic [15:0]        exp_s;

  dds_sweep_generator #(
    .DATA_WIDTH(16),
    .N(32),
    .ADDR_W(10),
    .AMP(16383)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .start_fcw(start_fcw),
    .step_fcw(step_fcw),
    .num_steps(num_steps),
    .dwell_cycles(dwell_cycles),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .fcw_out(fcw_out),
    .step_idx(step_idx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Presents a config with start high for one edge; returns just after E0.
  task automatic launch(input logic [31:0] f0, input logic [31:0] df,
                        input logic [15:0] ns, input logic [15:0] dw);
    start_fcw    = f0;
    step_fcw     = df;
    num_steps    = ns;
    dwell_cycles = dw;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Checks every edge of the 3-step, dwell-4 upward sweep from E1 to E13.
  task automatic run_sweep3(input string name);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_f = (k < 4) ? 32'h0040_0000 : (k < 8) ? 32'h0080_0000 : 32'h00C0_0000;
      exp_s = (k < 4) ? 16'd0 : (k < 8) ? 16'd1 : 16'd2;
      chk($sformatf("%s sample E%0d", name, k), sample_out, exp_sweep[k-1]);
      chk($sformatf("%s valid E%0d", name, k), sample_valid, 1);
      chk($sformatf("%s fcw E%0d", name, k), fcw_out, exp_f);
      chk($sformatf("%s step E%0d", name, k), step_idx, exp_s);
      chk($sformatf("%s done E%0d", name, k), done, 0);
      $display("%s E%0d sample=%0d fcw=%h step=%0d", name, k, sample_out, fcw_out, step_idx);
    end
    tick();
    chk({name, " done E13"}, done, 1);
    chk({name, " valid E13"}, sample_valid, 0);
    chk({name, " busy E13"}, busy, 0);
    tick();
    chk({name, " done E14"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    start_fcw = '0; step_fcw = '0; num_steps = '0; dwell_cycles = '0;
    tick();
    tick();
    chk("reset sample_out", sample_out, 0);
    chk("reset sample_valid", sample_valid, 0);
    chk("reset fcw_out", fcw_out, 0);
    chk("reset step_idx", step_idx, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst = 1'b0;
    tick();
    chk("idle busy", busy, 0);

    // 1. Fixed frequency.
    launch(32'h0040_0000, 32'h0, 16'd1, 16'd8);
    chk("fixed E0 busy", busy, 1);
    chk("fixed E0 fcw", fcw_out, 32'h0040_0000);
    chk("fixed E0 valid", sample_valid, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("fixed sample E%0d", k), sample_out, exp_fixed[k-1]);
      chk($sformatf("fixed valid E%0d", k), sample_valid, 1);
      $display("fixed E%0d sample=%0d", k, sample_out);
    end
    tick();
    chk("fixed done E9", done, 1);
    chk("fixed valid E9", sample_valid, 0);
    chk("fixed busy E9", busy, 0);
    tick();
    chk("fixed done E10", done, 0);

    // 2. Three-step sweep.
    launch(32'h0040_0000, 32'h0040_0000, 16'd3, 16'd4);
    chk("sweep E0 fcw", fcw_out, 32'h0040_0000);
    chk("sweep E0 step", step_idx, 0);
    run_sweep3("sweep");

    // 3. 1 kHz at 48 kHz.
    launch(32'd89478485, 32'h0, 16'd1, 16'd96);
    for (int k = 0; k < 96; k++) begin
      tick();
      chk($sformatf("audio valid %0d", k), sample_valid, 1);
      audio[k] = sample_out;
    end
    $display("audio s0=%0d s12=%0d s48=%0d s60=%0d", audio[0], audio[12], audio[48], audio[60]);
    chk("audio peak idx12", audio[12], 16383);
    chk("audio idx0", audio[0], 0);
    chk("audio idx48", audio[48], -101);
    for (int k = 1; k < 48; k++)
      chk($sformatf("audio period idx%0d", k), audio[k+48], audio[k]);
    tick();
    chk("audio done", done, 1);
    tick();

    // 4. Downward sweep.
    launch(32'h0080_0000, 32'hFFC0_0000, 16'd3, 16'd4);
    chk("down fcw E0", fcw_out, 32'h0080_0000);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) chk("down fcw E4", fcw_out, 32'h0040_0000);
      if (k == 8) chk("down fcw E8", fcw_out, 32'h0000_0000);
      if (k >= 9) chk($sformatf("down sample E%0d", k), sample_out, 1205);
      $display("down E%0d sample=%0d fcw=%h", k, sample_out, fcw_out);
    end
    tick();
    chk("down done", done, 1);
    tick();

    // 5a. Stop during step 1.
    launch(32'h0040_0000, 32'h0040_0000, 16'd3, 16'd4);
    for (int k = 1; k <= 5; k++) tick();
    chk("stop pre step", step_idx, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop valid", sample_valid, 0);
    chk("stop busy", busy, 0);
    chk("stop fcw", fcw_out, 0);
    chk("stop step", step_idx, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("stop no done %0d", k), done, 0);
    end
    $display("stop: valid=%0d busy=%0d", sample_valid, busy);

    // 5b. Reset mid-sweep.
    launch(32'h0040_0000, 32'h0040_0000, 16'd3, 16'd4);
    for (int k = 1; k <= 5; k++) tick();
    chk("rst pre busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst sample_out", sample_out, 0);
    chk("rst sample_valid", sample_valid, 0);
    chk("rst fcw_out", fcw_out, 0);
    chk("rst step_idx", step_idx, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    $display("mid-sweep reset: all outputs checked");
    tick();

    // 6. Start while busy is ignored.
    launch(32'h0040_0000, 32'h0040_0000, 16'd3, 16'd4);
    tick();
    chk("busy-start E1", sample_out, exp_sweep[0]);
    start_fcw    = 32'd123;
    step_fcw     = 32'd5;
    num_steps    = 16'd1;
    dwell_cycles = 16'd1;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    chk("busy-start E2", sample_out, exp_sweep[1]);
    for (int k = 3; k <= 12; k++) begin
      tick();
      exp_f = (k < 4) ? 32'h0040_0000 : (k < 8) ? 32'h0080_0000 : 32'h00C0_0000;
      chk($sformatf("busy-start sample E%0d", k), sample_out, exp_sweep[k-1]);
      chk($sformatf("busy-start fcw E%0d", k), fcw_out, exp_f);
      chk($sformatf("busy-start valid E%0d", k), sample_valid, 1);
      $display("busy-start E%0d sample=%0d fcw=%h", k, sample_out, fcw_out);
    end
    tick();
    chk("busy-start done E13", done, 1);
    chk("busy-start valid E13", sample_valid, 0);
    tick();

    // Back-to-back: start during the done cycle is sampled in IDLE.
    launch(32'h0040_0000, 32'h0, 16'd1, 16'd2);
    tick();
    tick();
    tick();
    chk("b2b first done", done, 1);
    launch(32'h0040_0000, 32'h0040_0000, 16'd3, 16'd4);
    chk("b2b E0 busy", busy, 1);
    chk("b2b E0 fcw", fcw_out, 32'h0040_0000);
    run_sweep3("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
